// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder, one full-adder slice and a carry flop, with
//               a Start/Busy/Done handshake. Optional macro: SUBTRACT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef SUBTRACT_EN
    input  logic             sub_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic             w_sum_bit;
    logic             w_carry_out;
    logic [WIDTH-1:0] w_a_shift;

`ifdef SUBTRACT_EN
    // Two's-complement subtract: invert B and force the carry-in high.
    assign w_b_load = sub_i ? ~b_i : b_i;
    assign w_c_load = sub_i | cin_i;
`else
    assign w_b_load = b_i;
    assign w_c_load = cin_i;
`endif

    assign w_sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    assign w_carry_out = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    // The A register doubles as the result shift register: each sum bit
    // enters at the MSB as the consumed operand bit leaves at the LSB.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign w_a_shift = w_sum_bit;
        end else begin : g_shift_wn
            assign w_a_shift = {w_sum_bit, a_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = w_b_load;
                    carry_d = w_c_load;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = w_a_shift;
                b_d     = b_q >> 1;
                carry_d = w_carry_out;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                    sum_d   = w_a_shift;
                    cout_d  = w_carry_out;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o = (state_q == S_RUN);
    assign done_o = (state_q == S_DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Scoreboard bench for serial_adder (WIDTH=8), random and
//               directed operations against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    typedef struct {
        logic [W:0] res;
        int         cyc;
    } exp_t;

    exp_t  q[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    last_start = 0;
    logic [W:0] held = '0;

    serial_adder #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .cin_i   (cin),
`ifdef SUBTRACT_EN
        .sub_i   (sub),
`endif
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum),
        .cout_o  (cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Monitor: pops the scoreboard on every Done cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held = '0;
        end else begin
            checks++;
            if (busy && done) begin
                errors++;
                $display("FAIL busy_done_overlap: busy=%0b done=%0b at cycle %0d", busy, done, cyc);
            end
            if (done) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got sum=%h cout=%0b, required no Done pulse (cycle %0d)", sum, cout, cyc);
                end else begin
                    e = q.pop_front();
                    checks++;
                    if ({cout, sum} !== e.res) begin
                        errors++;
                        $display("FAIL result: got cout=%0b sum=%h, required cout=%0b sum=%h", cout, sum, e.res[W], e.res[W-1:0]);
                    end
                    checks++;
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL latency: Done at cycle %0d, required cycle %0d", cyc, e.cyc);
                    end
                    held = e.res;
                end
            end else begin
                checks++;
                if ({cout, sum} !== held) begin
                    errors++;
                    $display("FAIL result_hold: got cout=%0b sum=%h, required held cout=%0b sum=%h", cout, sum, held[W], held[W-1:0]);
                end
            end
        end
    end

    // Called just after a rising edge; leaves the bench just after the load edge.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
        int   guard;
        exp_t e;
        guard = 0;
        while (busy) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 100) begin
                errors++;
                $display("FAIL issue_timeout: busy=%0b, required 0 within 100 cycles", busy);
                break;
            end
        end
        start = 1'b1;
        a = ta;
        b = tb;
        cin = tc;
        sub = ts;
        if (ts) e.res = {(ta >= tb) ? 1'b1 : 1'b0, ta - tb};
        else    e.res = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        @(posedge clk);
        #1;
        e.cyc = cyc + W;
        last_start = cyc;
        q.push_back(e);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (q.size() != 0 || busy) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 200) begin
                errors++;
                $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
                q.delete();
                break;
            end
        end
    endtask

    initial begin
        int n;
        int s1;
        int gap;
        logic s;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset then idle
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (busy || done || sum !== '0 || cout) begin
                errors++;
                $display("FAIL idle_after_reset: busy=%0b done=%0b sum=%h cout=%0b, required all 0", busy, done, sum, cout);
            end
        end
        @(posedge clk);
        #1;

        // Basic add, with busy duration measured
        issue(8'h5A, 8'h3C, 1'b0, 1'b0);
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            if (busy) n++;
        end
        checks++;
        if (n != W) begin
            errors++;
            $display("FAIL busy_cycles: got %0d, required %0d", n, W);
        end
        wait_drain();

        // Carry chain then back-to-back start in the Done cycle
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        s1 = last_start;
        issue(8'hFF, 8'hFF, 1'b1, 1'b0);
        checks++;
        if (last_start != s1 + W + 1) begin
            errors++;
            $display("FAIL back_to_back: second load at cycle %0d, required %0d", last_start, s1 + W + 1);
        end
        wait_drain();

        // Start during RUN is ignored
        issue(8'h01, 8'h01, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        @(posedge clk);
        #1 start = 1'b0;
        wait_drain();
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-operation
        issue(8'h5A, 8'h3C, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (busy || done || sum !== '0 || cout) begin
            errors++;
            $display("FAIL reset_abort: busy=%0b done=%0b sum=%h cout=%0b, required all 0", busy, done, sum, cout);
        end
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        issue(8'h33, 8'h44, 1'b1, 1'b0);
        wait_drain();

`ifdef SUBTRACT_EN
        issue(8'h10, 8'h01, 1'b0, 1'b1);
        issue(8'h01, 8'h02, 1'b1, 1'b1);
        issue(8'h5A, 8'h3C, 1'b0, 1'b0);
        wait_drain();
`endif

        // Randomised operations with random idle gaps
        for (int i = 0; i < 150; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
`ifdef SUBTRACT_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            issue(W'($urandom), W'($urandom), 1'($urandom), s);
        end
        wait_drain();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
